// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// FSM state encoding, the hard-wired zero register and the default
// data-memory timeout.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2,
      FLUSH      = 2'd3
   } hz_state_e;

   // $0 is never a real dependency: loads into it are discarded.
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Consecutive dmem_busy cycles tolerated before mem_timeout is raised.
   localparam int MEM_TIMEOUT_DEFAULT = 64;

endpackage : hazard_pkg

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the operands read
// by the instruction in ID. Purely combinational so the same compare can
// be reused by the forwarding unit.
module hazard_detect
   import hazard_pkg::*;
(
   input  logic       ex_memRead,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   output logic       hz
);

   logic rs_match;
   logic rt_match;

   // A hazard needs a real (non-$0) load target that ID actually reads.
   always_comb begin
      rs_match = id_use_rs && (id_rs == ex_rt);
      rt_match = id_use_rt && (id_rt == ex_rt);
      hz       = ex_memRead && (ex_rt != REG_ZERO) && (rs_match || rt_match);
   end

endmodule : hazard_detect

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// One prioritised FSM (RUN, LOAD_STALL, MEM_WAIT, FLUSH) produces every
// hold/flush/bubble control; outputs are combinational from state and
// current inputs. Priority: dmem_busy > ex_redirect > load-use > id_jump.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int LOAD_STALL_CYCLES = 1,                    // legal 1..3
   parameter int MEM_TIMEOUT       = MEM_TIMEOUT_DEFAULT,
   parameter int CNT_W             = 32
)
(
   input  logic       Clk,
   input  logic       reset,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       id_jump,
   input  logic       ex_memRead,
   input  logic [4:0] ex_rt,
   input  logic       ex_redirect,
   input  logic       dmem_busy,
   output logic       pc_stall,
   output logic       if_id_stall,
   output logic       if_id_flush,
   output logic       id_exe_stall,
   output logic       id_exe_empty,
   output logic       exe_mem_stall,
   output logic       mem_timeout
`ifdef HAZARD_STATS_EN
   ,
   output logic [CNT_W-1:0] stat_stall_cyc,
   output logic [CNT_W-1:0] stat_flush_cnt,
   output logic [CNT_W-1:0] stat_loaduse_cnt
`endif
);

   localparam int LS_W = 2;
   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

   hz_state_e        state_q, state_nxt;
   logic [LS_W-1:0]  ls_cnt_q, ls_cnt_nxt;
   logic [WC_W-1:0]  wait_cnt_q, wait_cnt_nxt, busy_cyc;
   logic             to_q, to_hit;
   logic             hz, go_run, go_ls, loaduse_evt;
   logic             pc_c, ifs_c, iff_c, ies_c, iee_c, ems_c;

   hazard_detect u_hazard_detect (
      .ex_memRead (ex_memRead),
      .ex_rt      (ex_rt),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_use_rs  (id_use_rs),
      .id_use_rt  (id_use_rt),
      .hz         (hz)
   );

   // Ordinal of the current busy cycle in this run (1 = first), saturating.
   always_comb begin
      busy_cyc = WC_W'(1);
      if (state_q == MEM_WAIT) begin
         if (wait_cnt_q >= WC_W'(MEM_TIMEOUT)) busy_cyc = WC_W'(MEM_TIMEOUT);
         else                                  busy_cyc = wait_cnt_q + WC_W'(1);
      end
   end

   // Next state and un-gated controls. A pending ls_cnt after MEM_WAIT means
   // the interrupted load-use stall resumes instead of normal RUN rules.
   always_comb begin
      state_nxt    = state_q;
      ls_cnt_nxt   = ls_cnt_q;
      wait_cnt_nxt = wait_cnt_q;
      go_run       = 1'b0;
      go_ls        = 1'b0;
      loaduse_evt  = 1'b0;
      to_hit       = 1'b0;
      pc_c         = 1'b0;
      ifs_c        = 1'b0;
      iff_c        = 1'b0;
      ies_c        = 1'b0;
      iee_c        = 1'b0;
      ems_c        = 1'b0;

      if (dmem_busy) begin
         pc_c         = 1'b1;
         ifs_c        = 1'b1;
         ies_c        = 1'b1;
         ems_c        = 1'b1;
         state_nxt    = MEM_WAIT;
         wait_cnt_nxt = busy_cyc;
         to_hit       = (busy_cyc >= WC_W'(MEM_TIMEOUT));
      end else begin
         wait_cnt_nxt = '0;
         case (state_q)
            FLUSH: begin
               iee_c     = 1'b1;
               state_nxt = RUN;
            end
            LOAD_STALL: go_ls = 1'b1;
            MEM_WAIT: begin
               if (ls_cnt_q != '0) go_ls  = 1'b1;
               else                go_run = 1'b1;
            end
            default: go_run = 1'b1;
         endcase
      end

      if (go_ls) begin
         pc_c       = 1'b1;
         ifs_c      = 1'b1;
         iee_c      = 1'b1;
         ls_cnt_nxt = ls_cnt_q - LS_W'(1);
         state_nxt  = (ls_cnt_q == LS_W'(1)) ? RUN : LOAD_STALL;
      end

      if (go_run) begin
         state_nxt = RUN;
         if (ex_redirect) begin
            iff_c     = 1'b1;
            iee_c     = 1'b1;
            state_nxt = FLUSH;
         end else if (hz) begin
            pc_c        = 1'b1;
            ifs_c       = 1'b1;
            iee_c       = 1'b1;
            loaduse_evt = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
               state_nxt  = LOAD_STALL;
               ls_cnt_nxt = LS_W'(LOAD_STALL_CYCLES - 1);
            end
         end else if (id_jump) begin
            iff_c = 1'b1;
         end
      end
   end

   // Reset overrides the outputs immediately, without waiting for a clock.
   always_comb begin
      if (!reset) begin
         pc_stall      = 1'b1;
         if_id_stall   = 1'b0;
         if_id_flush   = 1'b1;
         id_exe_stall  = 1'b0;
         id_exe_empty  = 1'b1;
         exe_mem_stall = 1'b0;
         mem_timeout   = 1'b0;
      end else begin
         pc_stall      = pc_c;
         if_id_stall   = ifs_c;
         if_id_flush   = iff_c;
         id_exe_stall  = ies_c;
         id_exe_empty  = iee_c;
         exe_mem_stall = ems_c;
         mem_timeout   = to_q | to_hit;
      end
   end

   // State, counters and the sticky timeout flag.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_q    <= RUN;
         ls_cnt_q   <= '0;
         wait_cnt_q <= '0;
         to_q       <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         ls_cnt_q   <= ls_cnt_nxt;
         wait_cnt_q <= wait_cnt_nxt;
         to_q       <= to_q | to_hit;
      end
   end

`ifdef HAZARD_STATS_EN
   // Event counters; they wrap naturally at 2^CNT_W.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         stat_stall_cyc   <= '0;
         stat_flush_cnt   <= '0;
         stat_loaduse_cnt <= '0;
      end else begin
         if (pc_stall)    stat_stall_cyc   <= stat_stall_cyc + CNT_W'(1);
         if (if_id_flush) stat_flush_cnt   <= stat_flush_cnt + CNT_W'(1);
         if (loaduse_evt) stat_loaduse_cnt <= stat_loaduse_cnt + CNT_W'(1);
      end
   end
`else
   // CNT_W only sizes the statistics counters; tie it off in the base build.
   logic unused_cnt_w;
   assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule : pipeline_hazard_ctrl

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Watches ID and EX stage contents, EX-resolved redirects and the data-memory busy line.
- Drives PC hold, IF/ID hold/flush, ID/EX stall and bubble (EMPTY), and EXE/MEM hold.
- Replaces the scattered ad-hoc stall logic with one prioritised FSM.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (2 when MEM->EX forwarding is absent); legal range 1..3.
- MEM_TIMEOUT, 64, maximum consecutive dmem_busy cycles before mem_timeout is raised.
- CNT_W, 32, width of the optional statistics counters.

Ports:
- Clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_jump  in  1  j/jal decoded in ID.
- ex_memRead  in  1  instruction in EX is a load.
- ex_rt  in  5  load destination register in EX.
- ex_redirect  in  1  taken branch or jr resolved in EX.
- dmem_busy  in  1  data memory not ready; MEM must hold.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID.
- if_id_flush  out  1  zero IF/ID on the next edge.
- id_exe_stall  out  1  drives ID_EXE_STALL.
- id_exe_empty  out  1  drives EMPTY (insert bubble).
- exe_mem_stall  out  1  hold EXE/MEM.
- mem_timeout  out  1  sticky error flag.

Behaviour:
- Clk and reset: single clock; reset asynchronous, active-low. This is fixed.
- FSM states: RUN, LOAD_STALL, MEM_WAIT, FLUSH. The state register and counters are clocked on Clk and cleared by reset.
- Outputs are combinational from the state and the current inputs.
- While reset is low:
  - state=RUN, counters=0, mem_timeout=0.
  - pc_stall=1, if_id_flush=1, id_exe_empty=1.
  - All other outputs are 0.
- Load-use hazard: hz = ex_memRead & (ex_rt!=0) & ((id_use_rs & id_rs==ex_rt) | (id_use_rt & id_rt==ex_rt)).
- Priority, highest first, evaluated each cycle in RUN:
  1. dmem_busy: pc_stall, if_id_stall, id_exe_stall and exe_mem_stall all =1. Go to MEM_WAIT; wait_cnt=1.
  2. ex_redirect: if_id_flush=1, id_exe_empty=1. Go to FLUSH.
  3. hz: pc_stall=1, if_id_stall=1, id_exe_empty=1. If LOAD_STALL_CYCLES>1, go to LOAD_STALL with ls_cnt=LOAD_STALL_CYCLES-1; otherwise stay in RUN.
  4. id_jump: if_id_flush=1, one cycle, to kill the fall-through fetch.
  5. Otherwise all outputs are 0.
- MEM_WAIT:
  - Same four stall outputs as item 1.
  - wait_cnt increments per cycle and saturates at MEM_TIMEOUT.
  - Reaching MEM_TIMEOUT sets mem_timeout; it stays set until reset. The stall continues regardless.
  - When dmem_busy falls, all stalls drop in that same cycle. Go to RUN, with rules 2-5 evaluated normally in that cycle.
- LOAD_STALL:
  - pc_stall=1, if_id_stall=1, id_exe_empty=1.
  - ls_cnt decrements; go to RUN when ls_cnt==1 at the edge.
  - dmem_busy pre-empts: go to MEM_WAIT and preserve ls_cnt; resume LOAD_STALL afterwards.
  - ex_redirect cannot occur here because EX holds a bubble.
- FLUSH (one cycle):
  - id_exe_empty=1; hazard detection is masked.
  - id_jump is ignored because the ID contents are squashed.
  - Returns to RUN. dmem_busy still pre-empts and is handled as in RUN.
- Simultaneous events resolve strictly by the priority list above.
- A redirect during a load-use hazard flushes and does not stall.
- id_exe_stall and id_exe_empty are never both 1 except under reset.
- ex_rt==0 never produces a hazard.
- Reset asserted mid-state returns to RUN immediately (asynchronous). The reset outputs apply until release.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined: add outputs stat_stall_cyc[CNT_W], stat_flush_cnt[CNT_W] and stat_loaduse_cnt[CNT_W].
  - stat_stall_cyc increments each cycle pc_stall=1 outside reset.
  - stat_flush_cnt increments on each if_id_flush.
  - stat_loaduse_cnt increments on each new hz detection in RUN.
  - All three wrap at 2^CNT_W and clear on reset.
- When undefined: these ports and counters do not exist and the core behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - the state encoding enum (RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3);
  - the REG_ZERO=5'd0 constant;
  - the default MEM_TIMEOUT.
- One sub-module, hazard_detect: purely combinational hz computation. This isolates the compare logic for reuse by the forwarding unit.

Test Plan:
- Load-use: ex_memRead=1, ex_rt=8, id_rs=8, id_use_rs=1, LOAD_STALL_CYCLES=1 -> exactly one cycle of pc_stall=if_id_stall=id_exe_empty=1, then all 0.
- Load to $0: ex_rt=0, id_rs=0, id_use_rs=1 -> no stall.
- LOAD_STALL_CYCLES=2 with the same hazard -> two bubble cycles; dmem_busy=1 for 3 cycles inserted after the first bubble -> 3 full-stall cycles, then the remaining bubble.
- ex_redirect=1 together with hz=1 and id_jump=1 -> if_id_flush=1, id_exe_empty=1, pc_stall=0. The next cycle (FLUSH) has id_exe_empty=1 only.
- MEM_TIMEOUT=4, dmem_busy held 6 cycles -> mem_timeout rises in the 4th busy cycle and stays 1 after busy falls, until reset.
- Assert reset in MEM_WAIT mid-cycle -> outputs switch to the reset values without a clock edge. After release, state=RUN and all outputs are 0 with idle inputs.
